// File: rtl/reset_sequencer.sv
// reset_sequencer: releases NUM_STAGES subsystem resets one at a time after
// the board reset deasserts. Each stage waits for its ready handshake (or a
// timeout, which is recorded in errMask) before the next stage is released.
// A software soft-reset request re-asserts every stage reset for a fixed
// hold time and then restarts the sequence from stage 0.
module reset_sequencer #(
    parameter int NUM_STAGES      = 3,
    parameter int STAGE_DELAY     = 16,
    parameter int TIMEOUT         = 65535,
    parameter int SOFT_RST_CYCLES = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  softRstReq,
    input  logic [NUM_STAGES-1:0] stageDone,
    output logic [NUM_STAGES-1:0] stageRst,
    output logic                  sysReady,
    output logic [2:0]            curStage,
    output logic [NUM_STAGES-1:0] errMask
);

    // The delay counter is shared by the per-stage delay and the soft-reset hold.
    localparam int DLY_MAX = (STAGE_DELAY > SOFT_RST_CYCLES) ? STAGE_DELAY : SOFT_RST_CYCLES;
    localparam int DW      = $clog2(DLY_MAX) + 1;
    localparam int TW      = $clog2(TIMEOUT) + 1;

    localparam logic [DW-1:0] DLY_LAST   = DW'(STAGE_DELAY - 1);
    localparam logic [DW-1:0] SOFT_LAST  = DW'(SOFT_RST_CYCLES - 1);
    localparam logic [DW-1:0] DLY_ONE    = DW'(1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TO_ONE     = TW'(1);
    localparam logic [2:0]    LAST_STAGE = 3'(NUM_STAGES - 1);

    typedef enum logic [1:0] {
        ST_DELAY = 2'd0,
        ST_WAIT  = 2'd1,
        ST_RUN   = 2'd2,
        ST_SOFT  = 2'd3
    } seqState_e;

    seqState_e             state;
    seqState_e             nextState;
    logic [DW-1:0]         dlyCnt;
    logic [TW-1:0]         toCnt;

    logic [DW-1:0]         dlyCntNext;
    logic [TW-1:0]         toCntNext;
    logic [NUM_STAGES-1:0] stageRstNext;
    logic                  sysReadyNext;
    logic [2:0]            curStageNext;
    logic [NUM_STAGES-1:0] errMaskNext;

    logic [NUM_STAGES-1:0] stageSel;
    logic                  doneNow;
    logic                  softHit;
    logic                  lastStage;

    // Decode the current stage index into a one-hot select and its handshake.
    always_comb begin
        for (int k = 0; k < NUM_STAGES; k++) begin
            stageSel[k] = (curStage == 3'(k));
        end
        doneNow   = |(stageDone & stageSel);
        softHit   = softRstReq && (state != ST_SOFT);
        lastStage = (curStage == LAST_STAGE);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_DELAY;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; a soft-reset request outranks every other transition.
    always_comb begin
        nextState = state;
        if (softHit) begin
            nextState = ST_SOFT;
        end else begin
            case (state)
                ST_DELAY: begin
                    if (dlyCnt == DLY_LAST) begin
                        nextState = ST_WAIT;
                    end else begin
                        nextState = ST_DELAY;
                    end
                end
                ST_WAIT: begin
                    if (doneNow || (toCnt == TO_LAST)) begin
                        nextState = lastStage ? ST_RUN : ST_DELAY;
                    end else begin
                        nextState = ST_WAIT;
                    end
                end
                ST_RUN: begin
                    nextState = ST_RUN;
                end
                ST_SOFT: begin
                    if (dlyCnt == SOFT_LAST) begin
                        nextState = ST_DELAY;
                    end else begin
                        nextState = ST_SOFT;
                    end
                end
                default: begin
                    nextState = ST_DELAY;
                end
            endcase
        end
    end

    // Next values of the counters and the registered outputs.
    always_comb begin
        dlyCntNext   = dlyCnt;
        toCntNext    = toCnt;
        stageRstNext = stageRst;
        sysReadyNext = sysReady;
        curStageNext = curStage;
        errMaskNext  = errMask;
        if (softHit) begin
            dlyCntNext   = {DW{1'b0}};
            toCntNext    = {TW{1'b0}};
            stageRstNext = {NUM_STAGES{1'b1}};
            sysReadyNext = 1'b0;
            curStageNext = 3'd0;
            errMaskNext  = {NUM_STAGES{1'b0}};
        end else begin
            case (state)
                ST_DELAY: begin
                    if (dlyCnt == DLY_LAST) begin
                        dlyCntNext   = {DW{1'b0}};
                        stageRstNext = stageRst & ~stageSel;
                    end else begin
                        dlyCntNext = dlyCnt + DLY_ONE;
                    end
                end
                ST_WAIT: begin
                    if (doneNow || (toCnt == TO_LAST)) begin
                        toCntNext = {TW{1'b0}};
                        // A handshake on the timeout edge still counts as on time.
                        if (!doneNow) begin
                            errMaskNext = errMask | stageSel;
                        end else begin
                            errMaskNext = errMask;
                        end
                        if (lastStage) begin
                            sysReadyNext = 1'b1;
                        end else begin
                            curStageNext = curStage + 3'd1;
                        end
                    end else begin
                        toCntNext = toCnt + TO_ONE;
                    end
                end
                ST_RUN: begin
                    sysReadyNext = sysReady;
                end
                ST_SOFT: begin
                    if (dlyCnt == SOFT_LAST) begin
                        dlyCntNext = {DW{1'b0}};
                    end else begin
                        dlyCntNext = dlyCnt + DLY_ONE;
                    end
                end
                default: begin
                    dlyCntNext = {DW{1'b0}};
                end
            endcase
        end
    end

    // Output and counter registers; rst forces the power-on values at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dlyCnt   <= {DW{1'b0}};
            toCnt    <= {TW{1'b0}};
            stageRst <= {NUM_STAGES{1'b1}};
            sysReady <= 1'b0;
            curStage <= 3'd0;
            errMask  <= {NUM_STAGES{1'b0}};
        end else begin
            dlyCnt   <= dlyCntNext;
            toCnt    <= toCntNext;
            stageRst <= stageRstNext;
            sysReady <= sysReadyNext;
            curStage <= curStageNext;
            errMask  <= errMaskNext;
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer. Stimulus pushes every expected output
// change (absolute clock-edge number plus the new output values) into a queue;
// a monitor watches the outputs on the falling edge and, whenever they change,
// pops the next expectation and compares edge number and values.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       softRstReq = 1'b0;
    logic [2:0] stageDone = 3'b000;
    logic [2:0] stageRst;
    logic       sysReady;
    logic [2:0] curStage;
    logic [2:0] errMask;

    int errors = 0;
    int checks = 0;
    int edgeNo = 0;

    typedef struct {
        int         edgeAt;
        logic [9:0] vals;
    } exp_t;

    exp_t       expQ[$];
    exp_t       popped;
    logic [9:0] obsNow;
    logic [9:0] prevObs = {3'b111, 1'b0, 3'b000, 3'b000};

    localparam logic [9:0] RESET_VALS = {3'b111, 1'b0, 3'b000, 3'b000};

    reset_sequencer #(
        .NUM_STAGES     (3),
        .STAGE_DELAY    (4),
        .TIMEOUT        (16),
        .SOFT_RST_CYCLES(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .softRstReq(softRstReq),
        .stageDone (stageDone),
        .stageRst  (stageRst),
        .sysReady  (sysReady),
        .curStage  (curStage),
        .errMask   (errMask)
    );

    assign obsNow = {stageRst, sysReady, curStage, errMask};

    always #5 clk = ~clk;

    always @(posedge clk) edgeNo <= edgeNo + 1;

    // Monitor: every output change must match the next queued expectation.
    always @(negedge clk) begin
        if (obsNow !== prevObs) begin
            prevObs = obsNow;
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change edge=%0d got rst=%b rdy=%b cur=%0d err=%b",
                         edgeNo, obsNow[9:7], obsNow[6], obsNow[5:3], obsNow[2:0]);
            end else begin
                popped = expQ.pop_front();
                if ((popped.edgeAt != edgeNo) || (popped.vals !== obsNow)) begin
                    errors++;
                    $display("FAIL seq_change got edge=%0d rst=%b rdy=%b cur=%0d err=%b want edge=%0d rst=%b rdy=%b cur=%0d err=%b",
                             edgeNo, obsNow[9:7], obsNow[6], obsNow[5:3], obsNow[2:0],
                             popped.edgeAt, popped.vals[9:7], popped.vals[6],
                             popped.vals[5:3], popped.vals[2:0]);
                end
            end
        end
    end

    task automatic rec(input int e, input logic [2:0] r, input logic s,
                       input logic [2:0] c, input logic [2:0] m);
        exp_t x;
        x.edgeAt = e;
        x.vals   = {r, s, c, m};
        expQ.push_back(x);
    endtask

    task automatic checkNow(input string name, input logic [9:0] want);
        checks++;
        if (obsNow !== want) begin
            errors++;
            $display("FAIL %s got %b want %b", name, obsNow, want);
        end
    endtask

    task automatic waitUntil(input int e);
        while (edgeNo < e) @(negedge clk);
    endtask

    task automatic releaseRst(output int b);
        @(negedge clk);
        rst = 1'b0;
        b   = edgeNo;
    endtask

    // Assert rst between edges; outputs must reset without any clock edge.
    task automatic assertRst(input string name);
        @(posedge clk);
        #1;
        rec(edgeNo, 3'b111, 1'b0, 3'd0, 3'b000);
        rst = 1'b1;
        #1;
        checkNow(name, RESET_VALS);
        repeat (2) @(negedge clk);
    endtask

    // Records for the stage-0 release and stage-0 handshake at edges 4 and 5.
    task automatic recStart(input int b);
        rec(b + 4, 3'b110, 1'b0, 3'd0, 3'b000);
        rec(b + 5, 3'b110, 1'b0, 3'd1, 3'b000);
        rec(b + 9, 3'b100, 1'b0, 3'd1, 3'b000);
    endtask

    int b;

    initial begin
        #1 rst = 1'b1;
        #1 checkNow("power_on_reset", RESET_VALS);
        repeat (2) @(negedge clk);

        // All stages already ready: fastest possible sequence.
        stageDone = 3'b111;
        releaseRst(b);
        recStart(b);
        rec(b + 10, 3'b100, 1'b0, 3'd2, 3'b000);
        rec(b + 14, 3'b000, 1'b0, 3'd2, 3'b000);
        rec(b + 15, 3'b000, 1'b1, 3'd2, 3'b000);
        waitUntil(b + 20);
        assertRst("rst_in_run");

        // Stage 1 handshake arrives 10 edges after its release.
        stageDone = 3'b101;
        releaseRst(b);
        recStart(b);
        rec(b + 19, 3'b100, 1'b0, 3'd2, 3'b000);
        rec(b + 23, 3'b000, 1'b0, 3'd2, 3'b000);
        rec(b + 24, 3'b000, 1'b1, 3'd2, 3'b000);
        waitUntil(b + 18);
        stageDone = 3'b111;
        waitUntil(b + 28);
        assertRst("rst_after_late_done");

        // Stage 1 never ready: timeout, then soft reset from RUN clears errMask.
        stageDone = 3'b101;
        releaseRst(b);
        recStart(b);
        rec(b + 25, 3'b100, 1'b0, 3'd2, 3'b010);
        rec(b + 29, 3'b000, 1'b0, 3'd2, 3'b010);
        rec(b + 30, 3'b000, 1'b1, 3'd2, 3'b010);
        rec(b + 33, 3'b111, 1'b0, 3'd0, 3'b000);
        rec(b + 45, 3'b110, 1'b0, 3'd0, 3'b000);
        rec(b + 46, 3'b110, 1'b0, 3'd1, 3'b000);
        rec(b + 50, 3'b100, 1'b0, 3'd1, 3'b000);
        rec(b + 51, 3'b100, 1'b0, 3'd2, 3'b000);
        rec(b + 55, 3'b000, 1'b0, 3'd2, 3'b000);
        rec(b + 56, 3'b000, 1'b1, 3'd2, 3'b000);
        waitUntil(b + 32);
        stageDone  = 3'b111;
        softRstReq = 1'b1;
        @(negedge clk);
        softRstReq = 1'b0;
        waitUntil(b + 35);
        softRstReq = 1'b1;
        @(negedge clk);
        softRstReq = 1'b0;
        waitUntil(b + 60);
        assertRst("rst_after_soft");

        // Handshake arrives exactly on the timeout edge: no error recorded.
        stageDone = 3'b101;
        releaseRst(b);
        recStart(b);
        rec(b + 25, 3'b100, 1'b0, 3'd2, 3'b000);
        rec(b + 29, 3'b000, 1'b0, 3'd2, 3'b000);
        rec(b + 30, 3'b000, 1'b1, 3'd2, 3'b000);
        waitUntil(b + 24);
        stageDone = 3'b111;
        waitUntil(b + 34);
        assertRst("rst_after_edge_done");

        // rst while waiting on stage 1, then a full restart.
        stageDone = 3'b101;
        releaseRst(b);
        recStart(b);
        waitUntil(b + 12);
        assertRst("rst_in_wait1");
        stageDone = 3'b111;
        releaseRst(b);
        recStart(b);
        rec(b + 10, 3'b100, 1'b0, 3'd2, 3'b000);
        rec(b + 14, 3'b000, 1'b0, 3'd2, 3'b000);
        rec(b + 15, 3'b000, 1'b1, 3'd2, 3'b000);
        waitUntil(b + 20);

        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL missing_changes got %0d pending want 0, next edge=%0d",
                     expQ.size(), expQ[0].edgeAt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
